// File: rtl/udc_pkg.sv
// Shared types and default widths for the up/down counter sweep sequencer.
package udc_pkg;

  localparam int unsigned DefWidth = 3;
  localparam int unsigned DefNswW  = 4;

  typedef enum logic [1:0] {
    StIdle,
    StUp,
    StDown,
    StDone
  } udc_state_t;

endpackage

// File: rtl/udc_sweep_ctrl_if.sv
// Request/status bundle between a sweep requester and udc_sweep_ctrl.
// Optional abort/aborted signals exist only when UDC_SWEEP_ABORT_EN is defined.
interface udc_sweep_ctrl_if #(
  parameter int unsigned WIDTH = udc_pkg::DefWidth,
  parameter int unsigned NSW_W = udc_pkg::DefNswW
);
  logic             start;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic [NSW_W-1:0] n_sweeps;
  logic             pause;
  logic [WIDTH-1:0] count;
  logic             dir;
  logic [NSW_W-1:0] sweep_cnt;
  logic             busy;
  logic             done;
`ifdef UDC_SWEEP_ABORT_EN
  logic             abort;
  logic             aborted;
`endif

  modport master (
    output start, lo, hi, n_sweeps, pause,
`ifdef UDC_SWEEP_ABORT_EN
    output abort,
    input  aborted,
`endif
    input  count, dir, sweep_cnt, busy, done
  );

  modport slave (
    input  start, lo, hi, n_sweeps, pause,
`ifdef UDC_SWEEP_ABORT_EN
    input  abort,
    output aborted,
`endif
    output count, dir, sweep_cnt, busy, done
  );

endinterface

// File: rtl/udc_step_counter.sv
// Loadable up/down step counter register; load takes priority over stepping.
module udc_step_counter
  import udc_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en) begin
      count_d = up ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/udc_sweep_ctrl.sv
// Sweep sequencer: drives the step counter lo->hi->lo for n_sweeps sweeps.
// Define UDC_SWEEP_ABORT_EN to add the abort/aborted early-termination path.
module udc_sweep_ctrl
  import udc_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned NSW_W = DefNswW
) (
  input logic             clk,
  input logic             reset,
  udc_sweep_ctrl_if.slave bus
);

  udc_state_t       state_q, state_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [NSW_W-1:0] n_q, n_d;
  logic [NSW_W-1:0] sweep_q, sweep_d;
  logic [NSW_W-1:0] sweep_inc;
  logic             dir_q, dir_d;
  logic             cnt_en, cnt_load, cnt_up;
  logic [WIDTH-1:0] count;
`ifdef UDC_SWEEP_ABORT_EN
  logic             aborted_q, aborted_d;
`endif

  udc_step_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clk      (clk),
    .reset    (reset),
    .en       (cnt_en),
    .load     (cnt_load),
    .load_val (bus.lo),
    .up       (cnt_up),
    .count    (count)
  );

  assign sweep_inc = sweep_q + NSW_W'(1);

  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    n_d      = n_q;
    sweep_d  = sweep_q;
    dir_d    = dir_q;
    cnt_en   = 1'b0;
    cnt_load = 1'b0;
    cnt_up   = 1'b1;
`ifdef UDC_SWEEP_ABORT_EN
    aborted_d = aborted_q;
`endif
    unique case (state_q)
      StIdle: begin
        dir_d = 1'b1;
        if (bus.start) begin
          lo_d     = bus.lo;
          hi_d     = bus.hi;
          n_d      = bus.n_sweeps;
          sweep_d  = '0;
          cnt_load = 1'b1;
`ifdef UDC_SWEEP_ABORT_EN
          aborted_d = 1'b0;
`endif
          // Empty range or zero sweeps completes immediately without stepping.
          if ((bus.lo >= bus.hi) || (bus.n_sweeps == '0)) begin
            state_d = StDone;
          end else begin
            state_d = StUp;
          end
        end
      end
      StUp: begin
`ifdef UDC_SWEEP_ABORT_EN
        if (bus.abort) begin
          state_d   = StDone;
          aborted_d = 1'b1;
        end else
`endif
        if (!bus.pause) begin
          cnt_en = 1'b1;
          // Turn around on the hi edge so hi is not repeated.
          if (count == hi_q) begin
            cnt_up  = 1'b0;
            dir_d   = 1'b0;
            state_d = StDown;
          end
        end
      end
      StDown: begin
`ifdef UDC_SWEEP_ABORT_EN
        if (bus.abort) begin
          state_d   = StDone;
          aborted_d = 1'b1;
        end else
`endif
        if (!bus.pause) begin
          if (count != lo_q) begin
            cnt_en = 1'b1;
            cnt_up = 1'b0;
          end else begin
            sweep_d = sweep_inc;
            if (sweep_inc == n_q) begin
              state_d = StDone;
            end else begin
              cnt_en  = 1'b1;
              dir_d   = 1'b1;
              state_d = StUp;
            end
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        dir_d   = 1'b1;
`ifdef UDC_SWEEP_ABORT_EN
        aborted_d = 1'b0;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      lo_q    <= '0;
      hi_q    <= '0;
      n_q     <= '0;
      sweep_q <= '0;
      dir_q   <= 1'b1;
`ifdef UDC_SWEEP_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      n_q     <= n_d;
      sweep_q <= sweep_d;
      dir_q   <= dir_d;
`ifdef UDC_SWEEP_ABORT_EN
      aborted_q <= aborted_d;
`endif
    end
  end

  assign bus.count     = count;
  assign bus.dir       = dir_q;
  assign bus.sweep_cnt = sweep_q;
  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = (state_q == StDone);
`ifdef UDC_SWEEP_ABORT_EN
  assign bus.aborted   = aborted_q;
`endif

endmodule

// File: tb/tb_udc_sweep_ctrl.sv
// Scoreboard bench for udc_sweep_ctrl: a trajectory-based reference model predicts
// every cycle's outputs; a negedge monitor compares. Honours UDC_SWEEP_ABORT_EN.
module tb_udc_sweep_ctrl;

  typedef struct packed {
    logic [2:0] count;
    logic       dir;
    logic [3:0] sweep;
    logic       busy;
    logic       done;
    logic       aborted;
  } obs_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  udc_sweep_ctrl_if #(.WIDTH(3), .NSW_W(4)) bus ();

  udc_sweep_ctrl #(
    .WIDTH (3),
    .NSW_W (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  obs_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Monitor: the DUT presents a full status word every cycle.
  always @(negedge clk) begin
    obs_t e, a;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.count = bus.count;
      a.dir   = bus.dir;
      a.sweep = bus.sweep_cnt;
      a.busy  = bus.busy;
      a.done  = bus.done;
`ifdef UDC_SWEEP_ABORT_EN
      a.aborted = bus.aborted;
`else
      a.aborted = 1'b0;
`endif
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL status@cyc%0d: got count=%0d dir=%0b sweep=%0d busy=%0b done=%0b abrt=%0b, want count=%0d dir=%0b sweep=%0d busy=%0b done=%0b abrt=%0b",
                 cyc, a.count, a.dir, a.sweep, a.busy, a.done, a.aborted,
                 e.count, e.dir, e.sweep, e.busy, e.done, e.aborted);
      end
    end
  end

  // Reference model: a run is the precomputed list of per-cycle observations.
  obs_t traj[$];
  int   idx;
  bit   in_run;
  obs_t cur;

  logic       r_reset_v;
  logic       r_start, r_pause, r_abort;
  logic [2:0] r_lo, r_hi;
  logic [3:0] r_n;

  function automatic obs_t mk(int c, bit d, int s, bit dn);
    obs_t o;
    o.count = 3'(c);
    o.dir = d;
    o.sweep = 4'(s);
    o.busy = 1'b1;
    o.done = dn;
    o.aborted = 1'b0;
    return o;
  endfunction

  task automatic build_traj(int lo, int hi, int n);
    traj.delete();
    if (lo >= hi || n == 0) begin
      traj.push_back(mk(lo, 1'b1, 0, 1'b1));
    end else begin
      traj.push_back(mk(lo, 1'b1, 0, 1'b0));
      for (int s = 0; s < n; s++) begin
        for (int c = lo + 1; c <= hi; c++) traj.push_back(mk(c, 1'b1, s, 1'b0));
        for (int c = hi - 1; c >= lo; c--) traj.push_back(mk(c, 1'b0, s, 1'b0));
      end
      traj.push_back(mk(lo, 1'b0, n, 1'b1));
    end
  endtask

  task automatic step();
    reset        = r_reset_v;
    bus.start    = r_start;
    bus.pause    = r_pause;
    bus.lo       = r_lo;
    bus.hi       = r_hi;
    bus.n_sweeps = r_n;
`ifdef UDC_SWEEP_ABORT_EN
    bus.abort    = r_abort;
`endif
    if (r_reset_v) begin
      cur = '0;
      cur.dir = 1'b1;
      in_run = 0;
    end else if (in_run) begin
      if (cur.done) begin
        cur.busy = 1'b0;
        cur.done = 1'b0;
        cur.dir = 1'b1;
        cur.aborted = 1'b0;
        in_run = 0;
`ifdef UDC_SWEEP_ABORT_EN
      end else if (r_abort) begin
        cur.done = 1'b1;
        cur.aborted = 1'b1;
`endif
      end else if (!r_pause) begin
        idx++;
        cur = traj[idx];
      end
    end else if (r_start) begin
      build_traj(int'(r_lo), int'(r_hi), int'(r_n));
      idx = 0;
      cur = traj[0];
      in_run = 1;
    end
    exp_q.push_back(cur);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(string tag);
    logic abrt;
`ifdef UDC_SWEEP_ABORT_EN
    abrt = bus.aborted;
`else
    abrt = 1'b0;
`endif
    n_tests++;
    if (bus.count !== 3'd0 || bus.dir !== 1'b1 || bus.sweep_cnt !== 4'd0 ||
        bus.busy !== 1'b0 || bus.done !== 1'b0 || abrt !== 1'b0) begin
      n_fail++;
      $display("FAIL reset state (%s): count=%0d dir=%0b sweep=%0d busy=%0b done=%0b abrt=%0b",
               tag, bus.count, bus.dir, bus.sweep_cnt, bus.busy, bus.done, abrt);
    end
  endtask

  task automatic clear_in();
    r_reset_v = 1'b0;
    r_start = 1'b0;
    r_pause = 1'b0;
    r_abort = 1'b0;
  endtask

  task automatic do_start(int lo, int hi, int n);
    clear_in();
    r_lo = 3'(lo);
    r_hi = 3'(hi);
    r_n = 4'(n);
    r_start = 1'b1;
    step();
    r_start = 1'b0;
    // Bounds change after the start edge; the run must not notice.
    r_lo = 3'($urandom_range(0, 7));
    r_hi = 3'($urandom_range(0, 7));
  endtask

  task automatic run_to_idle(int max_cyc);
    for (int i = 0; i < max_cyc && in_run; i++) step();
    n_tests++;
    if (in_run) begin
      n_fail++;
      $display("FAIL timeout: run still active after %0d cycles", max_cyc);
    end
    clear_in();
    step();
  endtask

  task automatic step_until(int c, bit d, int max_cyc);
    for (int i = 0; i < max_cyc && in_run && !(cur.count == 3'(c) && cur.dir == d); i++) step();
    n_tests++;
    if (!(in_run && cur.count == 3'(c) && cur.dir == d)) begin
      n_fail++;
      $display("FAIL timeout: count=%0d dir=%0b not reached within %0d cycles", c, d, max_cyc);
    end
  endtask

  initial begin
    clear_in();
    r_lo = '0;
    r_hi = '0;
    r_n = '0;
    r_reset_v = 1'b1;
    step();
    check_reset_state("initial");
    step();
    clear_in();
    step();

    // Single short sweep: 2,3,4,3,2 then done.
    do_start(2, 4, 1);
    run_to_idle(40);
    // Full range, two sweeps.
    do_start(0, 7, 2);
    run_to_idle(80);
    // Degenerate runs.
    do_start(5, 5, 3);
    run_to_idle(10);
    do_start(1, 6, 0);
    run_to_idle(10);
    do_start(6, 2, 1);
    run_to_idle(10);

    // Pause at 3 while counting up, with ignored start pulses.
    do_start(2, 6, 1);
    step_until(3, 1'b1, 20);
    r_pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      r_start = i[0];
      step();
    end
    clear_in();
    run_to_idle(40);

    // Reset mid-DOWN.
    do_start(1, 5, 1);
    step_until(3, 1'b0, 20);
    r_reset_v = 1'b1;
    step();
    check_reset_state("mid-down");
    clear_in();
    for (int i = 0; i < 3; i++) step();

`ifdef UDC_SWEEP_ABORT_EN
    do_start(1, 6, 2);
    step_until(4, 1'b1, 20);
    r_abort = 1'b1;
    r_pause = 1'b1;
    step();
    clear_in();
    run_to_idle(10);
`endif

    // Randomized runs.
    for (int run = 0; run < 40; run++) begin
      do_start(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 3)));
      for (int i = 0; i < 300 && in_run; i++) begin
        r_pause = ($urandom_range(0, 5) == 0);
        r_start = ($urandom_range(0, 3) == 0);
        r_lo = 3'($urandom_range(0, 7));
        r_hi = 3'($urandom_range(0, 7));
        r_reset_v = ($urandom_range(0, 149) == 0);
`ifdef UDC_SWEEP_ABORT_EN
        r_abort = ($urandom_range(0, 39) == 0);
`endif
        step();
      end
      clear_in();
      for (int i = 0; i < int'($urandom_range(1, 3)); i++) step();
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
